// File: rtl/alu_result_collector.sv
// Collects tagged results from the four ALU units into a small FIFO with valid/ready output.
// Optional ALU_COLLECTOR_PARITY_EN adds a stored per-entry even-parity output bit.
module alu_result_collector #(
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OUT_WIDTH-1:0]   arith_out,
  input  logic [OUT_WIDTH-1:0]   logic_out,
  input  logic [OUT_WIDTH-1:0]   cmp_out,
  input  logic [OUT_WIDTH-1:0]   shift_out,
  input  logic                   arith_flag,
  input  logic                   logic_flag,
  input  logic                   cmp_flag,
  input  logic                   shift_flag,
  input  logic                   err_clr,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic [1:0]             out_unit,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   collision_err,
  output logic                   overflow_err
`ifdef ALU_COLLECTOR_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
`ifdef ALU_COLLECTOR_PARITY_EN
  localparam int unsigned EW = OUT_WIDTH + 3;
`else
  localparam int unsigned EW = OUT_WIDTH + 2;
`endif

  logic [EW-1:0]        r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_coll_err;
  logic                 r_ovf_err;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_wr_en;
  logic                 w_overflow;
  logic                 w_collision;
  logic [1:0]           w_tag;
  logic [OUT_WIDTH-1:0] w_data;
  logic [EW-1:0]        w_entry;
  logic [EW-1:0]        w_head;
  logic [CW-1:0]        w_count_nxt;

  assign w_push      = arith_flag | logic_flag | cmp_flag | shift_flag;
  assign w_collision = (arith_flag & (logic_flag | cmp_flag | shift_flag)) |
                       (logic_flag & (cmp_flag | shift_flag)) |
                       (cmp_flag & shift_flag);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_wr_en     = w_push & (~w_full | w_pop);
  assign w_overflow  = w_push & w_full & ~w_pop;

  always_comb begin
    w_tag  = 2'b00;
    w_data = arith_out;
    if (arith_flag) begin
      w_tag  = 2'b00;
      w_data = arith_out;
    end else if (logic_flag) begin
      w_tag  = 2'b01;
      w_data = logic_out;
    end else if (cmp_flag) begin
      w_tag  = 2'b10;
      w_data = cmp_out;
    end else if (shift_flag) begin
      w_tag  = 2'b11;
      w_data = shift_out;
    end
  end

`ifdef ALU_COLLECTOR_PARITY_EN
  assign w_entry = {^{w_tag, w_data}, w_tag, w_data};
`else
  assign w_entry = {w_tag, w_data};
`endif

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_coll_err <= 1'b0;
      r_ovf_err  <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      // New error events take precedence over a simultaneous clear.
      if (w_collision)  r_coll_err <= 1'b1;
      else if (err_clr) r_coll_err <= 1'b0;
      if (w_overflow)   r_ovf_err  <= 1'b1;
      else if (err_clr) r_ovf_err  <= 1'b0;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign out_valid     = (r_count != '0);
  assign out_data      = out_valid ? w_head[OUT_WIDTH-1:0] : '0;
  assign out_unit      = out_valid ? w_head[OUT_WIDTH+1:OUT_WIDTH] : '0;
  assign fifo_count    = r_count;
  assign collision_err = r_coll_err;
  assign overflow_err  = r_ovf_err;
`ifdef ALU_COLLECTOR_PARITY_EN
  assign out_parity    = out_valid ? w_head[EW-1] : 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: vector table plus overflow, wrap and async-reset sequences.
module tb_alu_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] arith_out, logic_out, cmp_out, shift_out;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag;
  logic        err_clr, out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_unit;
  logic [2:0]  fifo_count;
  logic        collision_err, overflow_err;
`ifdef ALU_COLLECTOR_PARITY_EN
  logic        out_parity;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alu_result_collector #(.OUT_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .err_clr(err_clr), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_unit(out_unit),
    .fifo_count(fifo_count), .collision_err(collision_err), .overflow_err(overflow_err)
`ifdef ALU_COLLECTOR_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  typedef struct packed {
    logic [3:0]  flags;   // {arith, logic, cmp, shift}
    logic [15:0] ad, ld, cd, sd;
    logic        rdy, clr;
    logic        ev;
    logic [15:0] ed;
    logic [1:0]  eu;
    logic [2:0]  ec;
    logic        ecoll, eovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {arith_flag, logic_flag, cmp_flag, shift_flag} = 4'b0000;
    arith_out = '0; logic_out = '0; cmp_out = '0; shift_out = '0;
    err_clr = 1'b0;
  endtask

  initial begin
    logic [15:0] pops [5];
    pops[0] = 16'h0001; pops[1] = 16'h0002; pops[2] = 16'h0003;
    pops[3] = 16'h0004; pops[4] = 16'hAAAA;

    //           flags    ad       ld       cd       sd       rdy  clr  ev   ed       eu     ec    coll ovf
    vecs[0] = '{4'b0100, 16'h0,   16'h00F0, 16'h0,  16'h0,   1'b0, 1'b0, 1'b1, 16'h00F0, 2'd1, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{4'b0000, 16'h0,   16'h0,   16'h0,   16'h0,   1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{4'b1001, 16'h1234, 16'h0,  16'h0,   16'h5555, 1'b0, 1'b0, 1'b1, 16'h1234, 2'd0, 3'd1, 1'b1, 1'b0};
    vecs[3] = '{4'b0000, 16'h0,   16'h0,   16'h0,   16'h0,   1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0};
    vecs[4] = '{4'b0011, 16'h0,   16'h0,   16'h0C0C, 16'h0505, 1'b0, 1'b0, 1'b1, 16'h0C0C, 2'd2, 3'd1, 1'b1, 1'b0};
    vecs[5] = '{4'b0001, 16'h0,   16'h0,   16'h0,   16'h0ABC, 1'b0, 1'b0, 1'b1, 16'h0C0C, 2'd2, 3'd2, 1'b1, 1'b0};
    vecs[6] = '{4'b0110, 16'h0,   16'h0111, 16'h0222, 16'h0, 1'b1, 1'b1, 1'b1, 16'h0ABC, 2'd3, 3'd2, 1'b1, 1'b0};
    vecs[7] = '{4'b0000, 16'h0,   16'h0,   16'h0,   16'h0,   1'b1, 1'b1, 1'b1, 16'h0111, 2'd1, 3'd1, 1'b0, 1'b0};
    vecs[8] = '{4'b1000, 16'hBEEF, 16'h0,  16'h0,   16'h0,   1'b1, 1'b0, 1'b1, 16'hBEEF, 2'd0, 3'd1, 1'b0, 1'b0};
    vecs[9] = '{4'b0000, 16'h0,   16'h0,   16'h0,   16'h0,   1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0};

    rst = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_unit", 32'(out_unit), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_coll", 32'(collision_err), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      {arith_flag, logic_flag, cmp_flag, shift_flag} = vecs[i].flags;
      arith_out = vecs[i].ad; logic_out = vecs[i].ld;
      cmp_out   = vecs[i].cd; shift_out = vecs[i].sd;
      out_ready = vecs[i].rdy; err_clr = vecs[i].clr;
      tick();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
      chk($sformatf("v%0d_unit", i), 32'(out_unit), 32'(vecs[i].eu));
      chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].ec));
      chk($sformatf("v%0d_coll", i), 32'(collision_err), 32'(vecs[i].ecoll));
      chk($sformatf("v%0d_ovf", i), 32'(overflow_err), 32'(vecs[i].eovf));
    end

    // Overflow: five cmp pushes into a 4-deep FIFO with the consumer stalled.
    idle_inputs();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cmp_flag = 1'b1; cmp_out = 16'(i);
      tick();
      chk($sformatf("ovf_count%0d", i), 32'(fifo_count), (i > 4) ? 32'd4 : 32'(i));
      chk($sformatf("ovf_err%0d", i), 32'(overflow_err), (i > 4) ? 32'd1 : 32'd0);
    end
    idle_inputs();

    // Pop everything; the first pop coincides with a push of AAAA while full.
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("pop%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("pop%0d_data", k), 32'(out_data), 32'(pops[k]));
      chk($sformatf("pop%0d_unit", k), 32'(out_unit), 32'd2);
`ifdef ALU_COLLECTOR_PARITY_EN
      chk($sformatf("pop%0d_par", k), 32'(out_parity), 32'(^{2'b10, pops[k]}));
`endif
      out_ready = 1'b1;
      cmp_flag  = (k == 0);
      cmp_out   = 16'hAAAA;
      tick();
      if (k == 0) chk("fullpp_count", 32'(fifo_count), 32'd4);
      cmp_flag = 1'b0;
    end
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data", 32'(out_data), 32'd0);
    chk("drain_count", 32'(fifo_count), 32'd0);
    chk("ovf_sticky", 32'(overflow_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_clr", 32'(overflow_err), 32'd0);

    // Wrap-around: alternate push / pop across several pointer wraps.
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      out_ready = 1'b1;
      case (i % 4)
        0: begin arith_flag = 1'b1; arith_out = 16'h0100 + 16'(i); end
        1: begin logic_flag = 1'b1; logic_out = 16'h0100 + 16'(i); end
        2: begin cmp_flag   = 1'b1; cmp_out   = 16'h0100 + 16'(i); end
        default: begin shift_flag = 1'b1; shift_out = 16'h0100 + 16'(i); end
      endcase
      tick();
      chk($sformatf("wrap%0d_data", i), 32'(out_data), 32'h0100 + 32'(i));
      chk($sformatf("wrap%0d_unit", i), 32'(out_unit), 32'(i % 4));
      chk($sformatf("wrap%0d_count", i), 32'(fifo_count), 32'd1);
`ifdef ALU_COLLECTOR_PARITY_EN
      chk($sformatf("wrap%0d_par", i), 32'(out_parity), 32'(^{2'(i % 4), 16'h0100 + 16'(i)}));
`endif
      idle_inputs();
      tick();
      chk($sformatf("wrap%0d_empty", i), 32'(fifo_count), 32'd0);
    end

    // Asynchronous reset with three entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic_flag = 1'b1; logic_out = 16'h7000 + 16'(i);
      tick();
    end
    idle_inputs();
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(fifo_count), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_count", 32'(fifo_count), 32'd0);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream collection stage for the 16-bit ALU. Each cycle it samples the registered result/flag pairs of the four execution units (arithmetic, logic, compare, shift). It tags the valid result with its source unit and queues it in a small FIFO. Results are presented to the consumer over a valid/ready handshake, and collisions and overflow drops are reported through sticky error flags.

## Interface
- `OUT_WIDTH`, default 16: width of every unit result and of `out_data`.
- `DEPTH`, default 4: FIFO entries; a power of 2, minimum 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `arith_out`, `logic_out`, `cmp_out`, `shift_out`  in  OUT_WIDTH each  unit results.
- `arith_flag`, `logic_flag`, `cmp_flag`, `shift_flag`  in  1 each  result-valid for the matching unit.
- `err_clr`  in  1  synchronous clear of both sticky errors.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  OUT_WIDTH  head result.
- `out_unit`  out  2  head source tag: 00 arith, 01 logic, 10 cmp, 11 shift.
- `fifo_count`  out  $clog2(DEPTH)+1  occupancy.
- `collision_err`  out  1  sticky: more than one flag was seen in a cycle.
- `overflow_err`  out  1  sticky: a result was dropped because the FIFO was full.

## Operation
- Push request: any unit flag high.
  - Winner by fixed priority: arith > logic > cmp > shift.
  - Stored entry = {tag, result}.
  - Losing results are discarded.
- Collision: two or more flags high in the same cycle sets `collision_err`. The winner is still pushed.
- Pop: `out_valid && out_ready`. The read pointer advances.
- Storage:
  - Circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` holds 0..DEPTH.
- Full (`count == DEPTH`):
  - Push without pop: the entry is dropped, `overflow_err` is set, and pointers and count are unchanged.
  - Push with pop: both succeed and count is unchanged.
- Empty (`count == 0`):
  - Pop is impossible because `out_valid` = 0.
  - Push sets count to 1; the entry is visible the next cycle.
- Simultaneous push and pop when not full or empty: count is unchanged and both pointers advance.
- `err_clr`:
  - Clears both errors.
  - If a new error event occurs in the same cycle, set wins.
- `out_data` and `out_unit` are the head entry driven from storage. When empty they hold 0 (masked), not stale data.
- Reset mid-operation: pointers, count and errors go to 0 immediately; queued results are lost.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_unit` = 0, `fifo_count` = 0.
  - `collision_err` = 0, `overflow_err` = 0.
  - Storage contents are don't-care; they are masked by the empty state.
- Latency: a flag sampled at edge N gives `out_valid` = 1 with the data after edge N, i.e. one cycle later.
- Handshake:
  - `out_valid` does not depend combinationally on `out_ready`.
  - The head stays stable while `out_valid && !out_ready`.
- Throughput: one push and one pop per cycle sustained.
- Error flags assert the cycle after the triggering edge and hold until `err_clr` or reset.

## Configuration
- `ALU_COLLECTOR_PARITY_EN` defined:
  - Adds output `out_parity` (1 bit) = even parity (XOR reduction) of {`out_unit`, `out_data`].
  - Parity is computed at push and stored per entry.
  - Reset value 0; 0 when empty.
- `ALU_COLLECTOR_PARITY_EN` undefined: the port and the storage bit are absent; all other behaviour is identical.

## Test plan
- Reset then idle: all outputs 0. After rst is released and `logic_flag` = 1 with `logic_out` = 16'h00F0 for 1 cycle, the next cycle shows `out_valid` = 1, `out_data` = 16'h00F0, `out_unit` = 01, `fifo_count` = 1.
- Collision: `arith_flag` = `shift_flag` = 1 with `arith_out` = 16'h1234 -> one entry {00, 16'h1234} is queued, `collision_err` = 1. Pulsing `err_clr` returns it to 0.
- Overflow: `out_ready` = 0, 5 consecutive cmp pushes of 1..5 (DEPTH = 4) -> `fifo_count` = 4, `overflow_err` = 1. Popping returns 1, 2, 3, 4, and value 5 never appears.
- Full push+pop: with the FIFO full, set `out_ready` = 1 and push 16'hAAAA in the same cycle -> `fifo_count` stays 4 and 16'hAAAA is popped last after 4 more pops.
- Wrap-around: 10 alternating push/pop cycles with `out_ready` = 1 -> in-order delivery and correct tags across pointer wrap. `fifo_count` never exceeds 1.
- Reset mid-stream: 3 entries queued, rst asserted asynchronously -> `out_valid` and `fifo_count` drop to 0 before the next edge. Parity build: `out_parity` equals the XOR of {`out_unit`, `out_data`} on every pop.
